// File: rtl/alu_flag_seq.sv
// alu_flag_seq: multi-cycle A-B flag producer (Z, V, N) for the ALU compare path.
// Latency: start in cycle t -> busy t+1..t+NSLICE, valid pulse in t+NSLICE+1.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored during RUN.
// Ports: clk, reset (sync, active-high), start, A, B, Sign in; busy, valid, Z, V, N out.
// Optional macro FLAG_SEQ_ABORT_EN adds input abort (cancel a RUN without a result).
module alu_flag_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef FLAG_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
  output logic             busy,
  output logic             valid,
  output logic             Z,
  output logic             V,
  output logic             N
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             acc_q;      // any earlier slice result was nonzero
  logic             sign_q;
  logic [WIDTH-1:0] a_sh, b_sh; // operands shifted so the active slice sits at bit 0

  logic             abort_w;
  logic             accept;
  logic             last;
  logic [SLICE-1:0] a_sl, b_sl, slice_sum;
  logic             slice_cout;

`ifdef FLAG_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Abort only matters in RUN, except in DONE where it also suppresses a new start.
  assign accept = start & ((state_q == IDLE) | ((state_q == DONE) & ~abort_w));
  assign last   = (state_q == RUN) & (cnt_q == LAST_CNT);

  assign a_sl = a_sh[SLICE-1:0];
  assign b_sl = b_sh[SLICE-1:0];
  assign {slice_cout, slice_sum} = {1'b0, a_sl} + {1'b0, ~b_sl} + {{SLICE{1'b0}}, carry_q};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (abort_w)   state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == RUN);
    valid = (state_q == DONE);
  end

  // Slice datapath and flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      carry_q <= 1'b1;
      acc_q   <= 1'b0;
      sign_q  <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      Z       <= 1'b0;
      V       <= 1'b0;
      N       <= 1'b0;
    end else if (accept) begin
      a_sh    <= A;
      b_sh    <= B;
      sign_q  <= Sign;
      carry_q <= 1'b1;   // +1 of the two's-complement subtract
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else if ((state_q == RUN) && !abort_w) begin
      a_sh    <= a_sh >> SLICE;
      b_sh    <= b_sh >> SLICE;
      carry_q <= slice_cout;
      acc_q   <= acc_q | (|slice_sum);
      if (!last) cnt_q <= cnt_q + CW'(1);
      if (last) begin
        Z <= ~(acc_q | (|slice_sum));
        if (sign_q) begin
          // In the final slice the top bits are the operand/result MSBs.
          N <= slice_sum[SLICE-1];
          V <= (a_sl[SLICE-1] ^ b_sl[SLICE-1]) & (a_sl[SLICE-1] ^ slice_sum[SLICE-1]);
        end else begin
          N <= ~slice_cout;  // borrow out of the full-width subtract
          V <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_seq.sv
module tb_alu_flag_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Sign = 1'b0;
  logic        busy, valid, Z, V, N;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_zvn = 3'b000;  // flags the DUT should currently be holding

  always #5 clk = ~clk;

  alu_flag_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef FLAG_SEQ_ABORT_EN
    .abort (abort),
`endif
    .A     (A),
    .B     (B),
    .Sign  (Sign),
    .busy  (busy),
    .valid (valid),
    .Z     (Z),
    .V     (V),
    .N     (N)
  );

  // Reference flags {Z,V,N} from plain integer arithmetic.
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint d;
    logic [31:0] r;
    logic z, v, n;
    z = (a == b);
    r = a - b;
    if (s) begin
      d = longint'($signed(a)) - longint'($signed(b));
      v = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      n = r[31];
    end else begin
      v = 1'b0;
      n = (a < b);
    end
    return {z, v, n};
  endfunction

  // One operation from start to valid; checks latency, busy span, flag hold and result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string name);
    logic [2:0] e;
    int nb;
    int vc;
    vc = 0;
    nb = 0;
    @(negedge clk);
    start = 1'b1; A = a; B = b; Sign = s;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; Sign = 1'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (valid) begin vc = c; break; end
      if (busy) nb++;
      checks++;
      if ({Z, V, N} !== exp_zvn) begin
        errors++;
        $display("FAIL %s flag_hold cycle %0d: got %b want %b", name, c, {Z, V, N}, exp_zvn);
      end
      @(negedge clk);
    end
    e = model(a, b, s);
    checks++;
    if (vc != 5) begin
      errors++;
      $display("FAIL %s valid_latency: got %0d want 5", name, vc);
    end
    checks++;
    if (nb != 4) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want 4", name, nb);
    end
    checks++;
    if ({Z, V, N, busy} !== {e, 1'b0}) begin
      errors++;
      $display("FAIL %s flags ZVN/busy: got %b%b want %b0", name, {Z, V, N}, busy, e);
    end
    exp_zvn = e;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_pulse: valid=%b busy=%b want 0 0", name, valid, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, valid, Z, V, N} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000", {busy, valid, Z, V, N});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, valid, Z, V, N} !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b want 00000", {busy, valid, Z, V, N});
    end
    exp_zvn = 3'b000;
  endtask

  task automatic test_directed;
    do_op(32'd5, 32'd5, 1'b1, "equal_signed");
    do_op(32'h8000_0000, 32'd1, 1'b1, "signed_overflow");
    do_op(32'd1, 32'd2, 1'b0, "unsigned_borrow");
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, "unsigned_no_borrow");
    do_op(32'h0100_0000, 32'd0, 1'b1, "upper_slice_nonzero");
    do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, "signed_pos_overflow");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = ((i % 7) == 0) ? a : ((i % 5) == 0 ? (a ^ 32'h0000_0100) : 32'($urandom));
      do_op(a, b, 1'($urandom), "random");
    end
  endtask

  // start held continuously: ignored in RUN, accepted in DONE for a back-to-back op.
  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2;
    logic s1, s2;
    logic exp_busy, exp_valid;
    a1 = $urandom; b1 = $urandom; s1 = 1'b1;
    a2 = $urandom; b2 = a2;       s2 = 1'b0;
    @(negedge clk);
    start = 1'b1; A = a1; B = b1; Sign = s1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_busy  = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      exp_valid = (c == 5) || (c == 10);
      checks++;
      if (busy !== exp_busy || valid !== exp_valid) begin
        errors++;
        $display("FAIL b2b_handshake cycle %0d: busy=%b valid=%b want %b %b",
                 c, busy, valid, exp_busy, exp_valid);
      end
      if (c == 5 || c == 10) begin
        checks++;
        if ({Z, V, N} !== (c == 5 ? model(a1, b1, s1) : model(a2, b2, s2))) begin
          errors++;
          $display("FAIL b2b_flags cycle %0d: got %b want %b", c, {Z, V, N},
                   (c == 5 ? model(a1, b1, s1) : model(a2, b2, s2)));
        end
      end
      if (c == 1) begin A = a2; B = b2; Sign = s2; end
      if (c == 6) begin start = 1'b0; A = $urandom; B = $urandom; Sign = 1'b1; end
    end
    exp_zvn = model(a2, b2, s2);
  endtask

  task automatic test_reset_mid_run;
    int seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1; A = 32'd3; B = 32'd9; Sign = 1'b0;
    @(negedge clk);
    start = 1'b0;          // 1st RUN cycle
    @(negedge clk);
    reset = 1'b1;          // 2nd RUN cycle
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, valid, Z, V, N} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got %b want 00000", {busy, valid, Z, V, N});
    end
    exp_zvn = 3'b000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_run_quiet: active cycles %0d want 0", seen);
    end
  endtask

`ifdef FLAG_SEQ_ABORT_EN
  task automatic test_abort;
    int seen;
    seen = 0;
    do_op(32'd42, 32'd42, 1'b1, "abort_prior_equal");
    @(negedge clk);
    start = 1'b1; A = 32'd1; B = 32'd2; Sign = 1'b0;
    @(negedge clk); start = 1'b0;  // RUN 1
    @(negedge clk);                // RUN 2
    @(negedge clk); abort = 1'b1;  // RUN 3
    @(negedge clk); abort = 1'b0;
    checks++;
    if ({busy, valid, Z, V, N} !== {2'b00, exp_zvn}) begin
      errors++;
      $display("FAIL abort_idle: got %b want 00%b", {busy, valid, Z, V, N}, exp_zvn);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: active cycles %0d want 0", seen);
    end
    do_op(32'd1, 32'd2, 1'b0, "after_abort");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
`ifdef FLAG_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
